// File: rtl/fir_pkg.sv
// Shared constants for the symmetric 30-tap FIR filter: tap counts,
// the Q4.8 coefficient set and the accumulator guard width.
package fir_pkg;

    localparam int TAPS = 30;
    localparam int HALF = TAPS / 2;

    // Raw Q4.8 coefficients (value = raw / 256); tap k and tap 29-k share COE[k].
    localparam int COE [0:HALF-1] = '{-1, -1, -2, -2, -1, 1, 4, 7, 10, 13, 15, 18, 20, 21, 26};

    // Extra accumulator bits so the sum of HALF products can never overflow.
    localparam int ACC_GUARD_WL = $clog2(HALF) + 1;

endpackage

// File: rtl/fir_mac_lane.sv
// One symmetric lane: pre-add of the two mirrored taps, multiply by the
// lane coefficient, then floor the product to PROD_FRAC_WL fractional bits.
// The result stays aligned at FULL_FRAC_WL fractional bits so lanes sum directly.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int IN_WL        = 12,
    parameter int COE_WL       = 12,
    parameter int FULL_FRAC_WL = 16,
    parameter int PROD_FRAC_WL = 16,
    parameter int COE_VAL      = 0
) (
    input  logic signed [IN_WL-1:0]      x_a,
    input  logic signed [IN_WL-1:0]      x_b,
    output logic signed [IN_WL+COE_WL:0] prod
);

    localparam int PROD_WL = IN_WL + COE_WL + 1;
    localparam int SHIFT   = FULL_FRAC_WL - PROD_FRAC_WL;
    localparam logic signed [COE_WL-1:0]  COE_Q = COE_WL'(COE_VAL);
    // Clearing the low SHIFT bits of a two's-complement value is floor toward -inf.
    localparam logic        [PROD_WL-1:0] KEEP_MASK = {PROD_WL{1'b1}} << SHIFT;

    generate
        if (PROD_FRAC_WL > FULL_FRAC_WL || PROD_FRAC_WL < 0) begin : g_bad_frac
            $error("fir_mac_lane: PROD_FRAC_WL out of range");
        end
    endgenerate

    logic signed [IN_WL:0]   pre_sum;
    logic signed [PROD_WL-1:0] full_prod;

    assign pre_sum   = {x_a[IN_WL-1], x_a} + {x_b[IN_WL-1], x_b};
    assign full_prod = PROD_WL'(pre_sum) * PROD_WL'(COE_Q);
    assign prod      = full_prod & KEEP_MASK;

endmodule

// File: rtl/fir_filter.sv
// 30-tap linear-phase FIR: delay line, 15 symmetric MAC lanes with per-lane
// product truncation, adder, floor + saturation to the output format.
// Pipeline: sample capture -> registered products -> registered output.
module fir_filter
    import fir_pkg::*;
#(
    parameter int COE_INTE_WL = 4,
    parameter int COE_FRAC_WL = 8,
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 8,
    parameter int OUT_INTE_WL = 4,
    parameter int OUT_FRAC_WL = 8,
    parameter int PRODUCT_FRAC_WL_ARRAY [0:HALF-1] = '{13, 13, 14, 11, 10, 12, 10, 13, 10, 12, 12, 9, 13, 12, 11}
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic signed [IN_INTE_WL-1:-IN_FRAC_WL]   data_in,
    input  logic                                     in_valid,
    output logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL] data_out,
    output logic                                     out_valid
);

    localparam int IN_WL        = IN_INTE_WL + IN_FRAC_WL;
    localparam int COE_WL       = COE_INTE_WL + COE_FRAC_WL;
    localparam int OUT_WL       = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int FULL_FRAC_WL = IN_FRAC_WL + COE_FRAC_WL;
    localparam int PROD_WL      = IN_WL + COE_WL + 1;
    localparam int ACC_WL       = PROD_WL + ACC_GUARD_WL;
    localparam int OUT_SHIFT    = FULL_FRAC_WL - OUT_FRAC_WL;
    localparam logic signed [ACC_WL-1:0] SAT_MAX = ACC_WL'((2 ** (OUT_WL - 1)) - 1);
    localparam logic signed [ACC_WL-1:0] SAT_MIN = ACC_WL'(-(2 ** (OUT_WL - 1)));

    logic signed [IN_WL-1:0]   x_reg    [0:TAPS-1];
    logic signed [PROD_WL-1:0] lane_prod [0:HALF-1];
    logic signed [PROD_WL-1:0] prod_reg [0:HALF-1];
    logic                      v0_reg;
    logic                      v1_reg;
    logic signed [ACC_WL-1:0]  acc_sum;
    logic signed [ACC_WL-1:0]  acc_scaled;
    logic signed [OUT_WL-1:0]  out_next;

    // Delay line shifts only on accepted samples; v0 marks a fresh sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_reg[i] <= '0;
            end
            v0_reg <= 1'b0;
        end else begin
            v0_reg <= in_valid;
            if (in_valid) begin
                x_reg[0] <= data_in;
                for (int i = 1; i < TAPS; i++) begin
                    x_reg[i] <= x_reg[i-1];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_lane
            fir_mac_lane #(
                .IN_WL        (IN_WL),
                .COE_WL       (COE_WL),
                .FULL_FRAC_WL (FULL_FRAC_WL),
                .PROD_FRAC_WL (PRODUCT_FRAC_WL_ARRAY[gi]),
                .COE_VAL      (COE[gi])
            ) u_lane (
                .x_a  (x_reg[gi]),
                .x_b  (x_reg[TAPS-1-gi]),
                .prod (lane_prod[gi])
            );
        end
    endgenerate

    // Register truncated products when the delay line holds a new sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HALF; i++) begin
                prod_reg[i] <= '0;
            end
            v1_reg <= 1'b0;
        end else begin
            v1_reg <= v0_reg;
            if (v0_reg) begin
                for (int i = 0; i < HALF; i++) begin
                    prod_reg[i] <= lane_prod[i];
                end
            end
        end
    end

    // Sum the aligned products, floor to the output grid and saturate.
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < HALF; i++) begin
            acc_sum = acc_sum + ACC_WL'(prod_reg[i]);
        end
        acc_scaled = acc_sum >>> OUT_SHIFT;
        if (acc_scaled > SAT_MAX) begin
            out_next = OUT_WL'(SAT_MAX);
        end else if (acc_scaled < SAT_MIN) begin
            out_next = OUT_WL'(SAT_MIN);
        end else begin
            out_next = OUT_WL'(acc_scaled);
        end
    end

    // Output register: holds the last result while no new product arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1_reg;
            if (v1_reg) begin
                data_out <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: table-driven impulse vectors, model-backed scoreboard
// for DC / truncation / saturation, valid-gap and mid-burst reset sequences.
module tb_fir_filter;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [3:-8]  data_in = '0;
    logic signed [3:-8]  data_out;
    logic                out_valid;

    always #5 clk = ~clk;

    fir_filter dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int coe_ref  [0:14] = '{-1, -1, -2, -2, -1, 1, 4, 7, 10, 13, 15, 18, 20, 21, 26};
    int frac_ref [0:14] = '{13, 13, 14, 11, 10, 12, 10, 13, 10, 12, 12, 9, 13, 12, 11};

    int mx [0:29];
    int exp_q [$];
    bit vh1 = 1'b0;
    bit vh2 = 1'b0;
    int step_no = 0;

    typedef struct {
        bit v;
        int din;
        int exp;
    } vec_t;

    vec_t vec [0:33];

    function automatic int coe_of_tap(int j);
        return (j < 15) ? coe_ref[j] : coe_ref[29 - j];
    endfunction

    // Reference result for the current model history.
    function automatic int model_out();
        longint acc = 0;
        for (int k = 0; k < 15; k++) begin
            longint p  = longint'(mx[k] + mx[29 - k]);
            longint m  = p * coe_ref[k];
            int     sh = 16 - frac_ref[k];
            acc += (m >>> sh) <<< sh;
        end
        acc = acc >>> 8;
        if (acc > 2047)  acc = 2047;
        if (acc < -2048) acc = -2048;
        return int'(acc);
    endfunction

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, step_no, act, req);
        end
    endtask

    // One clock: drive inputs, update model/scoreboard, check outputs at edge+1.
    task automatic step(bit v, int din, int exp, bit use_tab);
        in_valid = v;
        data_in  = 12'(din);
        @(posedge clk);
        step_no++;
        if (v) begin
            for (int i = 29; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = din;
            exp_q.push_back(use_tab ? exp : model_out());
        end
        #1;
        check("out_valid", int'(out_valid), int'(vh2));
        vh2 = vh1;
        vh1 = v;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                $display("step %0d: data_out=%0d expected=%0d", step_no, int'(data_out), e);
                check("data_out", int'(data_out), e);
            end
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        in_valid = 1'b0;
        data_in  = '0;
        #3;
        rst = 1'b0;
        #1;
        check("rst_data_out", int'(data_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        exp_q.delete();
        for (int i = 0; i < 30; i++) mx[i] = 0;
        vh1 = 1'b0;
        vh2 = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 30; i++) mx[i] = 0;
        for (int i = 0; i < 34; i++) begin
            vec[i].v   = 1'b1;
            vec[i].din = (i == 0) ? 256 : 0;
            vec[i].exp = (i < 30) ? coe_of_tap(i) : 0;
        end

        // Power-on reset
        #1;
        do_reset();

        // Impulse, continuous valid
        for (int i = 0; i < 34; i++) step(vec[i].v, vec[i].din, vec[i].exp, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        do_reset();

        // Impulse with valid bubbles
        for (int i = 0; i < 34; i++) begin
            if (i % 3 == 1) step(1'b0, 0, 0, 1'b0);
            if (i % 7 == 4) step(1'b0, 0, 0, 1'b0);
            step(vec[i].v, vec[i].din, vec[i].exp, 1'b1);
        end
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        do_reset();

        // DC +1.0: settles at 256, held through idle cycles
        for (int i = 0; i < 40; i++) step(1'b1, 256, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("dc_pos_settle", int'(data_out), 256);
        do_reset();

        // DC -8.0: settles at -2048
        for (int i = 0; i < 40; i++) step(1'b1, -2048, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("dc_neg_settle", int'(data_out), -2048);
        do_reset();

        // Truncation: impulse of one LSB
        for (int i = 0; i < 34; i++) begin
            int e;
            e = (i < 30 && coe_of_tap(i) < 0) ? -1 : 0;
            step(1'b1, (i == 0) ? 1 : 0, e, 1'b1);
        end
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        do_reset();

        // Positive saturation pattern
        for (int i = 0; i < 30; i++) step(1'b1, (coe_of_tap(i) > 0) ? 2047 : -2048, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("sat_pos", int'(data_out), 2047);
        do_reset();

        // Negative saturation pattern
        for (int i = 0; i < 30; i++) step(1'b1, (coe_of_tap(i) > 0) ? -2048 : 2047, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("sat_neg", int'(data_out), -2048);
        do_reset();

        // Reset mid-burst, then impulse must reproduce cleanly
        for (int i = 0; i < 12; i++) step(vec[i].v, vec[i].din, vec[i].exp, 1'b1);
        do_reset();
        for (int i = 0; i < 34; i++) step(vec[i].v, vec[i].din, vec[i].exp, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
